// File: rtl/vga_fb_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared definitions for the VGA framebuffer:
//   - default display geometry and color width
//   - clear-engine FSM state type
//   - calc_aw(): RAM address width for a given resolution and scale
// -----------------------------------------------------------------------------
package vga_fb_pkg;

    localparam int DEF_HSIZE       = 800;
    localparam int DEF_VSIZE       = 600;
    localparam int DEF_SCALE_SHIFT = 2;
    localparam int DEF_PIX_W       = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // Address width of the stored (down-scaled) image. Never below 1 so a
    // degenerate single-entry RAM still has a legal address bus.
    function automatic int calc_aw(input int hsize, input int vsize, input int scale_shift);
        int depth;
        depth = (hsize >> scale_shift) * (vsize >> scale_shift);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// -----------------------------------------------------------------------------
// vga_fb_ram
// Simple dual-port RAM, one write port and one registered read port, both on
// the same clock. Read-during-write to the same address returns the old word
// (read-first). Written so that synthesis maps it onto block RAM.
//
// Ports:
//   clk    in           clock
//   we     in           write enable
//   waddr  in  [AW-1:0] write address
//   wdata  in  [DW-1:0] write data
//   raddr  in  [AW-1:0] read address
//   rdata  out [DW-1:0] read data, registered (one cycle after raddr)
// -----------------------------------------------------------------------------
module vga_fb_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 30000,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the array has no reset branch; a reset loop over every word would
    // stop block-RAM inference and turn the storage into flip-flops.
    // NOTE: non-blocking assignments make the read see the pre-write word,
    // which is exactly the read-first behaviour, and avoid simulation races.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vga_framebuffer.sv
// -----------------------------------------------------------------------------
// vga_framebuffer
// Framebuffer between pixel-drawing logic and the VGA output stage. The image
// is stored at (HSIZE x VSIZE) >> SCALE_SHIFT on each axis; every stored pixel
// is replicated over a 2^SCALE_SHIFT square of display pixels on scan-out.
//
// Build option: define VGA_FB_CLEAR_EN to include the hardware screen-clear
// engine. Without it CLEAR_REQ is ignored and CLEAR_BUSY is tied low.
//
// Ports:
//   PIXEL_CLK   in            pixel clock (single clock domain)
//   RST         in            asynchronous active-high reset
//   HC_I, VC_I  in  [9:0]     scan counters from the timing generator
//   PIXEL_DATA  out [PIX_W-1] scan color, 2 cycles after HC_I/VC_I sampled
//   WR_VALID    in            write request
//   WR_READY    out           write accepted when WR_VALID && WR_READY
//   WR_X, WR_Y  in  [9:0]     write position in stored units
//   WR_COLOR    in  [PIX_W-1] write data
//   CLEAR_REQ   in            single-cycle pulse starting a clear
//   CLEAR_BUSY  out           clear engine owns the write port
// -----------------------------------------------------------------------------
module vga_framebuffer
    import vga_fb_pkg::*;
#(
    parameter int               HSIZE       = DEF_HSIZE,
    parameter int               VSIZE       = DEF_VSIZE,
    parameter int               SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int               PIX_W       = DEF_PIX_W,
    parameter logic [PIX_W-1:0] BLANK_COLOR = '0,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
    input  logic             PIXEL_CLK,
    input  logic             RST,
    input  logic [9:0]       HC_I,
    input  logic [9:0]       VC_I,
    output logic [PIX_W-1:0] PIXEL_DATA,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [9:0]       WR_X,
    input  logic [9:0]       WR_Y,
    input  logic [PIX_W-1:0] WR_COLOR,
    input  logic             CLEAR_REQ,
    output logic             CLEAR_BUSY
);

    localparam int SW    = HSIZE >> SCALE_SHIFT;
    localparam int SH    = VSIZE >> SCALE_SHIFT;
    localparam int DEPTH = SW * SH;
    localparam int AW    = calc_aw(HSIZE, VSIZE, SCALE_SHIFT);

    localparam logic [AW-1:0] SW_A    = AW'(SW);
    localparam logic [9:0]    HSIZE_C = 10'(HSIZE);
    localparam logic [9:0]    VSIZE_C = 10'(VSIZE);
    localparam logic [9:0]    SW_C    = 10'(SW);
    localparam logic [9:0]    SH_C    = 10'(SH);

    // ------------------------------------------------------------------
    // Scan pipeline: address/blank (edge N) -> RAM data (N+1) -> output (N+2)
    // ------------------------------------------------------------------
    logic [9:0]       hc_s, vc_s;
    logic [AW-1:0]    scan_addr_d, scan_addr_q;
    logic             blank_d, blank_q;
    logic             blank_dly_d, blank_dly_q;
    logic [PIX_W-1:0] pixel_d, pixel_q;
    logic [PIX_W-1:0] ram_rdata;

    // Write side
    logic             rdy_d, rdy_q;
    logic             clear_busy;
    logic             wr_fire;
    logic             wr_in_range;
    logic [AW-1:0]    wr_addr;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [PIX_W-1:0] ram_wdata;

    assign hc_s = HC_I >> SCALE_SHIFT;
    assign vc_s = VC_I >> SCALE_SHIFT;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        blank_d     = !((HC_I < HSIZE_C) && (VC_I < VSIZE_C));
        // Only meaningful when visible; off-screen reads are masked by blank.
        scan_addr_d = AW'(vc_s) * SW_A + AW'(hc_s);
        blank_dly_d = blank_q;
        pixel_d     = blank_dly_q ? BLANK_COLOR : ram_rdata;
        // Comes up one edge after reset release and then stays high.
        rdy_d       = 1'b1;
    end

    always_ff @(posedge PIXEL_CLK or posedge RST) begin
        if (RST) begin
            scan_addr_q <= '0;
            blank_q     <= 1'b1;
            blank_dly_q <= 1'b1;
            pixel_q     <= BLANK_COLOR;
            rdy_q       <= 1'b0;
        end else begin
            scan_addr_q <= scan_addr_d;
            blank_q     <= blank_d;
            blank_dly_q <= blank_dly_d;
            pixel_q     <= pixel_d;
            rdy_q       <= rdy_d;
        end
    end

    assign PIXEL_DATA = pixel_q;
    assign WR_READY   = rdy_q && !clear_busy;
    assign CLEAR_BUSY = clear_busy;

    // Out-of-range writes still complete the handshake; they just never
    // reach the RAM.
    assign wr_fire     = WR_VALID && WR_READY;
    assign wr_in_range = (WR_X < SW_C) && (WR_Y < SH_C);
    assign wr_addr     = AW'(WR_Y) * SW_A + AW'(WR_X);

`ifdef VGA_FB_CLEAR_EN
    // ------------------------------------------------------------------
    // Clear engine: sweeps address 0..DEPTH-1, one word per cycle.
    // ------------------------------------------------------------------
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    fb_state_e     state_d, state_q;
    logic [AW-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (CLEAR_REQ) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // A repeated CLEAR_REQ here is deliberately ignored.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge PIXEL_CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);

    // WR_READY is low while clearing, so the two sources never collide.
    assign ram_we    = clear_busy || (wr_fire && wr_in_range);
    assign ram_waddr = clear_busy ? cnt_q : wr_addr;
    assign ram_wdata = clear_busy ? CLEAR_COLOR : WR_COLOR;
`else
    logic unused_clear_req;
    assign unused_clear_req = CLEAR_REQ;

    assign clear_busy = 1'b0;
    assign ram_we     = wr_fire && wr_in_range;
    assign ram_waddr  = wr_addr;
    assign ram_wdata  = WR_COLOR;
`endif

    vga_fb_ram #(
        .DW    (PIX_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (PIXEL_CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (scan_addr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Parametrised framebuffer between the pixel-drawing logic and the VGA timing/output stage. Holds an image stored at reduced resolution (the display resolution divided by 2^SCALE_SHIFT on each axis) in block RAM. Accepts pixel writes through a valid/ready handshake and serves scan reads addressed by the timing generator's counters. Includes a hardware screen-clear engine.

## Interface
- HSIZE, 800: visible display width in pixels
- VSIZE, 600: visible display height in pixels
- SCALE_SHIFT, 2: each stored pixel covers a 2^SCALE_SHIFT × 2^SCALE_SHIFT block of display pixels
- PIX_W, 8: color width in bits
- BLANK_COLOR, 0: color driven outside the visible area
- CLEAR_COLOR, 0: value written by the clear engine
- Derived values: SW = HSIZE>>SCALE_SHIFT, SH = VSIZE>>SCALE_SHIFT, DEPTH = SW*SH, AW = $clog2(DEPTH)
- PIXEL_CLK  in  1  pixel clock; all logic is in this single clock domain
- RST  in  1  asynchronous, active-high reset
- HC_I  in  10  scan horizontal counter
- VC_I  in  10  scan vertical counter
- PIXEL_DATA  out  PIX_W  scan color output
- WR_VALID  in  1  write request
- WR_READY  out  1  write accepted when WR_VALID && WR_READY
- WR_X  in  10  write column, in stored units (0..SW-1)
- WR_Y  in  10  write row, in stored units (0..SH-1)
- WR_COLOR  in  PIX_W  write data
- CLEAR_REQ  in  1  single-cycle pulse that starts a clear
- CLEAR_BUSY  out  1  high while the clear engine owns the write port

## Operation
- Storage is a simple dual-port RAM: one read port for scan, one write port shared by the writer and the clear engine. RAM contents are not reset.
- Scan read: if HC_I < HSIZE and VC_I < VSIZE, the address is (VC_I>>SCALE_SHIFT)*SW + (HC_I>>SCALE_SHIFT). Otherwise a registered blank flag forces PIXEL_DATA to BLANK_COLOR.
- Write: a transfer occurs when WR_VALID && WR_READY. The address is WR_Y*SW + WR_X. A write with WR_X ≥ SW or WR_Y ≥ SH is accepted but dropped, and RAM is left untouched.
- WR_READY = !CLEAR_BUSY, and it is 0 while RST is high.
- FSM has two states, IDLE and CLEAR:
  - IDLE → CLEAR on CLEAR_REQ. The clear counter loads 0 and CLEAR_BUSY rises the next cycle.
  - In CLEAR, the engine writes CLEAR_COLOR to address cnt each cycle and increments cnt.
  - At cnt = DEPTH-1, the engine writes that last address, then returns to IDLE.
  - CLEAR_REQ while in CLEAR is ignored.
  - If CLEAR_REQ and a handshake occur in the same IDLE cycle, the write is performed and the clear starts the next cycle.
- Read-during-write to the same address returns the old data (read-first).
- Multiplies use constant SW and are sized to AW bits. Counter inputs are 10 bits; the design requires HSIZE and VSIZE ≤ 1023.

## Timing
- Scan latency is 2 cycles: HC_I/VC_I sampled at edge N, address and blank flag registered at N, RAM data at N+1, PIXEL_DATA valid after edge N+2. The timing generator delays sync signals by 2 to match.
- A write accepted at edge N is visible to a scan read issued at edge N+1 or later.
- A clear takes exactly DEPTH cycles of CLEAR_BUSY=1 (30000 with defaults).
- Reset values: PIXEL_DATA = BLANK_COLOR, WR_READY = 0, CLEAR_BUSY = 0, FSM in IDLE, counter = 0. WR_READY rises on the first edge after RST deasserts.
- Reset during a clear aborts it immediately. RAM is left partially cleared, and no resume occurs.

## Configuration
- VGA_FB_CLEAR_EN
  - Defined: the clear engine, FSM and CLEAR_BUSY logic are built.
  - Undefined: CLEAR_REQ is ignored, CLEAR_BUSY is tied to 0, and WR_READY equals !RST. No clear-related logic is synthesised.

## Structure
- Package vga_fb_pkg holds:
  - default HSIZE, VSIZE, SCALE_SHIFT and PIX_W
  - the FSM state typedef (IDLE, CLEAR)
  - a function computing AW from the resolution and scale
- Sub-module vga_fb_ram: parametrised simple dual-port, read-first, registered-output RAM (PIX_W × DEPTH) that infers block RAM.
- The top level contains the address arithmetic, blank pipeline, write arbitration and clear FSM.

## Test plan
- Reset: hold RST 5 cycles → PIXEL_DATA = 0, WR_READY = 0, CLEAR_BUSY = 0; one cycle after release, WR_READY = 1.
- Write (X=10, Y=5, color 0x45), then scan HC=40..43, VC=20..23 → PIXEL_DATA = 0x45 for all 16 positions, 2 cycles after each sample; HC=44 returns the neighbouring stored pixel.
- Blanking: scan HC=800 or VC=600 → PIXEL_DATA = BLANK_COLOR, regardless of RAM contents.
- Out-of-range write (X=200, Y=0, color 0xFF) → handshake completes and every address (0..DEPTH-1) is unchanged.
- Clear: preload RAM with 0xAA, pulse CLEAR_REQ → CLEAR_BUSY high for exactly 30000 cycles, WR_READY low throughout, all of RAM reads 0; a second CLEAR_REQ mid-clear does not extend the clear.
- Reset mid-clear (assert RST at count 1000) → CLEAR_BUSY = 0 immediately; addresses 0..≤1000 cleared, remaining addresses still hold 0xAA.
